// File: rtl/watch_mode_ctrl.sv
// Mode/set controller for the second-resolution watch: owns the 1 Hz prescaler,
// the minute/second registers, the RUN/SET_MIN/SET_SEC sequencing and the set-mode blink flag.
module watch_mode_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10
    } state_t;

    state_t        state;
    logic [PW-1:0] pcnt;
    logic          wrap;
    logic          do_mode;
    logic          do_up;
    logic          do_down;

    // Only the highest-priority pulse of a cycle is acted on; the rest are dropped.
    assign do_mode = btn_mode;
    assign do_up   = btn_up & ~btn_mode;
    assign do_down = btn_down & ~btn_mode & ~btn_up;

    assign wrap = (pcnt == PCNT_LAST);
    assign mode = state;

    // Out-of-range values (unreachable) fold back to 0 on the next update.
    function automatic logic [5:0] inc59(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec59(input logic [5:0] v);
        if (v == 6'd0)
            return 6'd59;
        else if (v > 6'd59)
            return 6'd0;
        else
            return v - 6'd1;
    endfunction

    // NOTE: every register here is updated with non-blocking assignments so all
    // next-state terms read the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pcnt  <= '0;
            tick  <= 1'b0;
            min   <= 6'd0;
            sec   <= 6'd0;
            blink <= 1'b1;
        end else begin
            tick <= wrap;
            pcnt <= wrap ? '0 : pcnt + PW'(1);

            case (state)
                RUN: begin
                    blink <= 1'b1;
                    if (wrap) begin
                        if (sec == 6'd59) begin
                            sec <= 6'd0;
                            min <= inc59(min);
                        end else begin
                            sec <= inc59(sec);
                        end
                    end
                    if (do_mode) begin
                        state <= SET_MIN;
                        blink <= 1'b0;
                    end
                end

                SET_MIN: begin
                    if (wrap)
                        blink <= ~blink;
                    if (do_mode) begin
                        state <= SET_SEC;
                    end else if (do_up) begin
                        min   <= inc59(min);
                        blink <= 1'b1;
                    end else if (do_down) begin
                        min   <= dec59(min);
                        blink <= 1'b1;
                    end
                end

                SET_SEC: begin
                    if (wrap)
                        blink <= ~blink;
                    // Leaving SET_SEC restarts the second so the first RUN step is a full period.
                    if (do_mode) begin
                        state <= RUN;
                        blink <= 1'b1;
                        pcnt  <= '0;
                    end else if (do_up) begin
                        sec   <= inc59(sec);
                        blink <= 1'b1;
                        pcnt  <= '0;
                    end else if (do_down) begin
                        sec   <= dec59(sec);
                        blink <= 1'b1;
                        pcnt  <= '0;
                    end
                end

                default: begin
                    state <= RUN;
                    blink <= 1'b1;
                end
            endcase
        end
    end

endmodule
